serial_twos_negator: RTL
========================

Name: serial_twos_negator

Overview:
- Parametrised, multi-cycle two's-complement unit for the ALU datapath: negate, absolute value or pass-through on a WIDTH-bit operand.
- Processes DIGIT bits per clock, LSB first, using a single registered carry, which trades latency for area on wide operands.
- Valid/ready handshakes on both input and output so it can sit between ALU operand registers and the result bus.
- Flags overflow when the most-negative value is negated.

Parameters:
- WIDTH, 16, operand/result width in bits; must be at least 2.
- DIGIT, 4, bits processed per RUN cycle; must divide WIDTH exactly.
- STEPS (local, not overridable), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rstN  input  1  asynchronous, active-low reset.
- inValid  input  1  operand and mode are valid.
- inReady  output  1  block can accept an operand.
- a  input  WIDTH  operand, two's complement.
- mode  input  2  operation select: 00 pass, 01 negate, 10 abs, 11 reserved (treated as pass).
- outValid  output  1  result and flags are valid.
- outReady  input  1  downstream accepts the result.
- result  output  WIDTH  computed value.
- ovf  output  1  operation required negation and a was 1 followed by all zeros (result equals a).
- zero  output  1  result is all zeros.

Behaviour:
- Reset (rstN low, asynchronous):
  - State goes to IDLE; inReady=0 while rstN is low.
  - outValid=0, result=0, ovf=0, zero=0; internal carry, operand and digit counter cleared.
  - Reset mid-RUN or mid-DONE abandons the operation with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - inReady=1, outValid=0.
  - On a rising edge with inValid=1:
    - latch a and mode;
    - compute doNeg = (mode==01) or (mode==10 and a[WIDTH-1]);
    - carry=doNeg, counter=0;
    - go to RUN.
- RUN:
  - inReady=0, outValid=0.
  - Each edge processes digit k = counter, bits [k*DIGIT +: DIGIT]:
    - sum = (doNeg ? ~a_digit : a_digit) + carry;
    - write the low DIGIT bits of sum into result at the same position;
    - carry = carry-out of sum;
    - counter increments.
  - After the edge that processes digit STEPS-1, go to DONE.
  - Inputs a, mode and inValid are ignored throughout RUN.
- DONE:
  - outValid=1, inReady=0.
  - result, ovf and zero are held stable until a rising edge with outReady=1, then go to IDLE.
  - No new operand is accepted in the same cycle as the output handshake.
- Latency and throughput:
  - outValid rises exactly STEPS cycles after the accepting edge.
  - Minimum spacing between accepted operands is STEPS+2 cycles.
- Flags:
  - ovf = doNeg and a == {1'b1, (WIDTH-1)'b0}; registered, valid in DONE.
  - zero = (result == 0); valid in DONE.
  - Negating 0 gives result 0, zero=1, ovf=0; the final carry is discarded.
- Mode rules:
  - mode 11 behaves exactly as 00: result=a, ovf=0.
  - Abs of a non-negative a is a pass-through.
- result is driven only from registers; there is no combinational path from input ports to outputs.
- Parameter checks: elaboration fails (generate-time error) if WIDTH%DIGIT != 0 or WIDTH<2.

Test Plan:
1. WIDTH=8, DIGIT=4, mode=01, a=0x05 -> result=0xFB, ovf=0, zero=0; outValid rises 2 cycles after accept; inReady=0 throughout.
2. WIDTH=8, DIGIT=4, mode=01: a=0x80 -> result=0x80, ovf=1; then a=0x00 -> result=0x00, zero=1, ovf=0.
3. WIDTH=16, DIGIT=4, mode=10: a=0xFFF6 -> 0x000A; a=0x000A -> 0x000A; a=0x8000 -> 0x8000 with ovf=1; mode=11, a=0x1234 -> 0x1234, ovf=0.
4. Backpressure: hold outReady=0 for 5 cycles in DONE while toggling a and inValid -> result/flags stable, outValid=1, inReady=0; after outReady=1, IDLE with inReady=1 on the next cycle.
5. Pull rstN low during the 2nd RUN cycle of a 16/4 negate -> outputs zero immediately (asynchronously); after release, negate 0x0001 -> 0xFFFF with correct latency 4.
6. WIDTH=16, DIGIT=1, mode=01, a=0x0001 -> result=0xFFFF after exactly 16 cycles; back-to-back operands accepted no closer than 18 cycles apart.

Source files
------------

// File: rtl/serial_twos_negator_if.sv
// Operand/result handshake bundle for serial_twos_negator.
// The master side supplies operands and accepts results; the slave side is the negator.
interface serial_twos_negator_if #(
    parameter int WIDTH = 16
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] a;
    logic [1:0]       mode;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             zero;

    modport master (
        output inValid, a, mode, outReady,
        input  inReady, outValid, result, ovf, zero
    );

    modport slave (
        input  inValid, a, mode, outReady,
        output inReady, outValid, result, ovf, zero
    );
endinterface

// File: rtl/serial_twos_negator.sv
// Digit-serial two's-complement pass/negate/abs unit.
// Processes DIGIT bits per cycle, LSB first, using one registered carry.
module serial_twos_negator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                  clk,
    input logic                  rstN,
    serial_twos_negator_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_twos_negator: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] res;
    logic             do_neg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid;

    logic [DIGIT-1:0] digit;
    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] res_next;
    logic             accept_neg;
    int               base;

    // Negation is ~a + 1: the +1 enters as the initial carry, then ripples digit by digit.
    always_comb begin
        base       = DIGIT * int'(cnt);
        digit      = op[base +: DIGIT];
        sum        = {1'b0, (do_neg ? ~digit : digit)} + {{DIGIT{1'b0}}, carry};
        res_next   = res;
        res_next[base +: DIGIT] = sum[DIGIT-1:0];
        accept_neg = (bus.mode == 2'b01) || (bus.mode == 2'b10 && bus.a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            op        <= '0;
            res       <= '0;
            do_neg    <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.inValid) begin
                        op     <= bus.a;
                        do_neg <= accept_neg;
                        carry  <= accept_neg;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= sum[DIGIT];
                    if (cnt == CW'(STEPS - 1)) begin
                        // Flags are taken from the completed result so they settle with DONE.
                        ovf_q     <= do_neg && (op == MOST_NEG);
                        zero_q    <= (res_next == '0);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.outReady) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // inReady is gated by rstN so it is low for the whole time reset is asserted.
    assign bus.inReady  = (state == IDLE) && rstN;
    assign bus.outValid = out_valid;
    assign bus.result   = res;
    assign bus.ovf      = ovf_q;
    assign bus.zero     = zero_q;
endmodule
